// File: rtl/pipe_mux_tree_if.sv
// Handshake bundle between the input-port buffers, the pipelined mux tree and the router output port.
interface pipe_mux_tree_if #(
  parameter int unsigned NUM_IN = 6,
  parameter int unsigned WIDTH  = 1
);
  localparam int unsigned SEL_W = $clog2(NUM_IN);

  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]        in_sel;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_err;

  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_err
  );

  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_err
  );
endinterface

// File: rtl/pipe_mux_tree.sv
// Pipelined NUM_IN:1 binary selector tree, one register stage per level, valid/ready backpressure.
// Optional macro PMUX_RANGE_CHECK_EN flags in_sel >= NUM_IN and forces that item's data to zero.
module pipe_mux_tree #(
  parameter int unsigned NUM_IN = 6,
  parameter int unsigned WIDTH  = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  pipe_mux_tree_if.slave bus
);
  localparam int unsigned SEL_W  = $clog2(NUM_IN);
  localparam int unsigned LEVELS = SEL_W;

  // Node count entering tree level lvl; odd tails are promoted, hence the round-up.
  function automatic int unsigned node_cnt(input int unsigned lvl);
    int unsigned n;
    n = NUM_IN;
    for (int unsigned i = 0; i < lvl; i++) begin
      n = (n + 1) / 2;
    end
    return n;
  endfunction

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int unsigned N_IN  = node_cnt(k);
    localparam int unsigned N_OUT = (N_IN + 1) / 2;
    localparam int unsigned S_W   = SEL_W - k;

    logic [N_IN-1:0][WIDTH-1:0]  d_in;
    logic [S_W-1:0]              s_in;
    logic                        v_in;
    logic [N_OUT-1:0][WIDTH-1:0] d_mux;
    logic [N_OUT-1:0][WIDTH-1:0] d_nxt;
    logic [N_OUT-1:0][WIDTH-1:0] d_q;
    logic                        v_q;
    logic                        load_c;
    logic                        nxt_load;

    if (k == 0) begin : g_src
      assign d_in = bus.in_data;
      assign s_in = bus.in_sel;
      assign v_in = bus.in_valid;
    end else begin : g_src
      assign d_in = g_lvl[k-1].d_q;
      assign s_in = g_lvl[k-1].g_sel.s_q;
      assign v_in = g_lvl[k-1].v_q;
    end

    // Pair nodes (2j, 2j+1) on the lowest remaining select bit; a lone last node passes through.
    for (genvar j = 0; j < N_OUT; j++) begin : g_node
      if (2 * j + 1 < N_IN) begin : g_pair
        assign d_mux[j] = s_in[0] ? d_in[2*j+1] : d_in[2*j];
      end else begin : g_pass
        assign d_mux[j] = d_in[2*j];
      end
    end

`ifdef PMUX_RANGE_CHECK_EN
    logic e_in;
    logic e_q;

    if (k == 0) begin : g_err_src
      assign e_in = ({1'b0, bus.in_sel} >= (SEL_W + 1)'(NUM_IN));
    end else begin : g_err_src
      assign e_in = g_lvl[k-1].e_q;
    end

    assign d_nxt = e_in ? '0 : d_mux;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        e_q <= 1'b0;
      end else if (load_c) begin
        e_q <= e_in;
      end
    end
`else
    assign d_nxt = d_mux;
`endif

    if (k == LEVELS - 1) begin : g_tail
      assign nxt_load = bus.out_ready;
    end else begin : g_tail
      assign nxt_load = g_lvl[k+1].load_c;
    end

    // A stage may load when empty or when its content moves on this cycle (bubble collapse).
    assign load_c = !v_q || nxt_load;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        d_q <= '0;
      end else if (load_c) begin
        v_q <= v_in;
        d_q <= d_nxt;
      end
    end

    // Only the select bits still needed by later levels are carried forward.
    if (S_W > 1) begin : g_sel
      logic [S_W-2:0] s_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s_q <= '0;
        end else if (load_c) begin
          s_q <= s_in[S_W-1:1];
        end
      end
    end
  end

  assign bus.in_ready  = g_lvl[0].load_c;
  assign bus.out_data  = g_lvl[LEVELS-1].d_q;
  assign bus.out_valid = g_lvl[LEVELS-1].v_q;

`ifdef PMUX_RANGE_CHECK_EN
  assign bus.out_err = g_lvl[LEVELS-1].e_q;
`else
  assign bus.out_err = 1'b0;
`endif

endmodule

// File: doc/pipe_mux_tree.md
# pipe_mux_tree

Parametrised, pipelined N-to-1 selector tree for router fan-in paths. It generalises the fixed 6:1 single-bit binary mux tree to NUM_IN channels of WIDTH bits, with one register stage per tree level. Valid/ready handshaking with backpressure gives full throughput and a fixed latency when the output is not stalled. It sits between input-port buffers and a router output port, with the select driven by the port-allocation logic.

## Interface
Parameters:
- NUM_IN, 6: number of input channels; legal range 2..64.
- WIDTH, 1: bits per channel; at least 1.
- SEL_W, derived as clog2(NUM_IN): select width and number of tree levels (LEVELS). This is a localparam, not overridable.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  NUM_IN*WIDTH  packed channels; channel i occupies [i*WIDTH +: WIDTH].
- in_sel  in  SEL_W  channel index; bit k steers tree level k.
- in_valid  in  1  input item present.
- in_ready  out  1  tree accepts the item this cycle.
- out_data  out  WIDTH  selected channel.
- out_valid  out  1  output item present.
- out_ready  in  1  consumer accepts the output this cycle.
- out_err  out  1  out-of-range select flag; tied to 0 unless PMUX_RANGE_CHECK_EN is defined.

## Operation
Tree structure:
- Level 0 pairs the channels (2i, 2i+1): sel[0]=0 picks the even channel, 1 picks the odd channel.
- If a level has an odd node count, the last node is promoted unchanged to the next level; its select bit is ignored.
- Level k pairs the nodes of level k-1 the same way, using sel[k].
- For NUM_IN=6 this gives: level 0 {0,1},{2,3},{4,5}; level 1 {01,23} with node 45 promoted; level 2 {0123,45}.

Pipeline:
- Each level has a register stage holding the level's node vector, a valid bit, the unused upper select bits, and the error bit.
- Stage s is loaded when it is empty or when stage s+1 is loaded (or, for the last stage, when out_ready=1).
- in_ready equals the load condition of stage 0.
- A transfer occurs on in_valid & in_ready, and on out_valid & out_ready.
- A stalled stage holds its contents stable.
- out_data, out_valid and out_err are taken directly from the last stage. There is no combinational path from in_data to out_data.
- in_ready depends combinationally on out_ready through the stage chain; this path is intentional.

Out-of-range select (in_sel >= NUM_IN) without the macro:
- Follows the tree structure deterministically.
- For NUM_IN=6, sel=6 yields ch4 and sel=7 yields ch5.

Reset:
- Asserting rst_n=0 clears all stage valid bits, data, select and error registers to 0 immediately, regardless of the clock.
- Outputs during and after reset: out_valid=0, out_data=0, out_err=0. in_ready=1 once rst_n=1.
- Items in flight are discarded; there is no drain.

## Timing
- Latency: exactly LEVELS cycles from the accepting edge to out_valid, with no stall (3 for NUM_IN=6, 1 for NUM_IN=2).
- Throughput: one item per cycle while out_ready=1.
- Full pipeline with out_ready=0: in_ready=0 in the same cycle. No item is dropped or duplicated.
- Output released while the pipe is full: a new input is accepted in the same cycle (pipelined ready, no bubble).
- Output stalled mid-pipe: bubbles collapse, so upstream stages still fill while downstream stages hold.
- in_sel and in_data are sampled only on the accepting edge. Changes while in_ready=0 have no effect.

## Configuration
PMUX_RANGE_CHECK_EN:
- Defined: in_sel >= NUM_IN is detected at stage 0. That item travels with err=1 and data forced to 0, and appears with out_err=1, out_data=0, out_valid=1.
- Undefined: no check logic is built. out_err is constant 0 and out-of-range selects follow the tree structure.

## Test plan
- NUM_IN=6, WIDTH=8, channels 0x10..0x15, in_sel swept 0..5 back-to-back with out_ready=1: out_data 0x10..0x15 in order on cycles 3..8 after the first accept, out_valid continuous.
- Same stream with out_ready held 0 from cycle 2 to 7: in_ready falls once 3 items are held, no loss or duplication, and order is preserved after release.
- in_sel=6 and 7: without the macro, 0x14 and 0x15; with PMUX_RANGE_CHECK_EN, out_data=0x00 and out_err=1 for each, and in-range items still give out_err=0.
- rst_n pulsed low mid-stream with 2 items in flight: out_valid=0 and out_data=0 immediately (asynchronous); after release in_ready=1 and no stale item ever emerges.
- NUM_IN=2, WIDTH=32: sel=1 gives in_1 with 1-cycle latency. NUM_IN=5: sel=4 gives channel 4 (promoted node) after 3 cycles.
- Random valid/ready toggling over 10k items on NUM_IN=6, checked against a reference queue: exact order and data match, and out_data stays stable while out_valid & !out_ready.
